// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Index arithmetic wraps modulo the requester count, which need not be a power of two.
package mux_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned N_DEFAULT     = 32'd4;
  localparam int unsigned IDX_W_DEFAULT = $clog2(N_DEFAULT);

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational masked priority picker: first set request at or after i_start, wrapping.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  // Scan from farthest to nearest so the closest request after i_start wins.
  always_comb begin
    int pos;
    pos     = 0;
    o_idx   = '0;
    o_found = |i_req;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      pos = int'(i_start) + k;
      if (pos >= int'(N)) begin
        pos = pos - int'(N);
      end else begin
        pos = pos;
      end
      if (i_req[IW'(pos)]) begin
        o_idx = IW'(pos);
      end else begin
        o_idx = o_idx;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning an N:1 bit-select datapath, with a burst limit
// that forces rotation when another requester is waiting.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned N         = N_DEFAULT,
  parameter int unsigned MAX_BURST = 32'd8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N-1:0]         i_req,
  input  logic [N-1:0]         i_w,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_sel,
  output logic                 o_busy,
  output logic                 o_f,
  output logic                 o_f_valid
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_BURST + 32'd1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
  localparam logic [N-1:0]  ONE_HOT0 = N'(32'd1);

  arb_state_e    r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_sel;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_gnt;
  logic          r_busy;
  logic          r_f;
  logic          r_f_valid;

  logic [IW-1:0] w_start;
  logic          w_found;
  logic [IW-1:0] w_idx;
  logic [N-1:0]  w_pick_oh;
  logic          w_hold;
  logic          w_others;
  logic          w_data;

  // While granted, every new pick starts just past the current holder.
  always_comb begin
    w_start = r_ptr;
    if (r_state == GRANT) begin
      w_start = IW'(wrap_inc(32'(r_sel), N));
    end else begin
      w_start = r_ptr;
    end
  end

  assign w_pick_oh = ONE_HOT0 << w_idx;
  assign w_hold    = i_req[r_sel];
  assign w_others  = |(i_req & ~r_gnt);
  assign w_data    = i_w[r_sel];

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .i_req   (i_req),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // Arbitration FSM with registered grant, select and sampled data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_f       <= 1'b0;
      r_f_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_f_valid <= 1'b0;
          if (w_found) begin
            r_gnt   <= w_pick_oh;
            r_sel   <= w_idx;
            r_busy  <= 1'b1;
            r_cnt   <= CNT_ONE;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (!w_hold) begin
            r_f_valid <= 1'b0;
            r_ptr     <= w_start;
            if (w_found) begin
              r_gnt <= w_pick_oh;
              r_sel <= w_idx;
              r_cnt <= CNT_ONE;
            end else begin
              r_gnt   <= '0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_f       <= w_data;
            r_f_valid <= 1'b1;
            if ((r_cnt == CNT_MAX) && w_others) begin
              r_ptr <= w_start;
              r_gnt <= w_pick_oh;
              r_sel <= w_idx;
              r_cnt <= CNT_ONE;
            end else if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_gnt     <= '0;
          r_busy    <= 1'b0;
          r_f_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_sel     = r_sel;
  assign o_busy    = r_busy;
  assign o_f       = r_f;
  assign o_f_valid = r_f_valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed scoreboard bench for mux_rr_arbiter with N=4, MAX_BURST=4.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] w;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       f;
  logic       f_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    int         sel;
    logic       busy;
    logic       f;
    logic       fv;
  } exp_t;

  exp_t sb[$];

  mux_rr_arbiter #(.N(4), .MAX_BURST(4)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_w       (w),
    .o_gnt     (gnt),
    .o_sel     (sel),
    .o_busy    (busy),
    .o_f       (f),
    .o_f_valid (f_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] g, input int s,
                      input logic b, input logic fe, input logic fv);
    exp_t e;
    e.tag = tag; e.gnt = g; e.sel = s; e.busy = b; e.f = fe; e.fv = fv;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard", "empty", 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, "gnt", 8'(gnt), 8'(e.gnt));
      if (e.sel >= 0) chk(e.tag, "sel", 8'(sel), 8'(e.sel));
      chk(e.tag, "busy", 8'(busy), 8'(e.busy));
      chk(e.tag, "f", 8'(f), 8'(e.f));
      chk(e.tag, "f_valid", 8'(f_valid), 8'(e.fv));
    end
  endtask

  task automatic step(input string tag, input logic [3:0] rq, input logic [3:0] wv,
                      input logic [3:0] g, input int s, input logic b, input logic fe, input logic fv);
    @(negedge clk);
    req = rq;
    w   = wv;
    push(tag, g, s, b, fe, fv);
    @(posedge clk);
    #1;
    sample();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    w     = 4'b0000;

    // 1: reset holds everything low even with all requests up
    push("t1_rst_hold", 4'b0000, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    sample();
    @(negedge clk);
    rst_n = 1'b1;
    push("t1_rst_rel", 4'b0001, 0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    sample();
    step("t1_drop", 4'b0000, 4'b0000, 4'b0000, -1, 1'b0, 1'b0, 1'b0);

    // 2: single grant, sample, release, pointer wrap
    step("t2_gnt",  4'b0100, 4'b0100, 4'b0100, 2,  1'b1, 1'b0, 1'b0);
    step("t2_smp",  4'b0100, 4'b0100, 4'b0100, 2,  1'b1, 1'b1, 1'b1);
    step("t2_rel",  4'b0000, 4'b0100, 4'b0000, -1, 1'b0, 1'b1, 1'b0);
    step("t2_wrap", 4'b0111, 4'b0000, 4'b0001, 0,  1'b1, 1'b1, 1'b0);

    // 3: back-to-back handoff as each holder drops
    step("t3_g0",   4'b1111, 4'b1010, 4'b0001, 0,  1'b1, 1'b0, 1'b1);
    step("t3_g1",   4'b1110, 4'b1010, 4'b0010, 1,  1'b1, 1'b0, 1'b0);
    step("t3_g2",   4'b1100, 4'b1010, 4'b0100, 2,  1'b1, 1'b0, 1'b0);
    step("t3_g3",   4'b1000, 4'b1010, 4'b1000, 3,  1'b1, 1'b0, 1'b0);
    step("t3_idle", 4'b0000, 4'b1010, 4'b0000, -1, 1'b0, 1'b0, 1'b0);

    // 4: two persistent requesters rotate every 4 cycles
    for (int i = 1; i <= 10; i++) begin
      logic       second;
      second = (i >= 5) && (i <= 8);
      step($sformatf("t4_c%0d", i), 4'b0011, 4'b0010,
           second ? 4'b0010 : 4'b0001, second ? 1 : 0, 1'b1,
           ((i >= 6) && (i <= 9)) ? 1'b1 : 1'b0, (i >= 2) ? 1'b1 : 1'b0);
    end
    step("t4_rel", 4'b0000, 4'b0010, 4'b0000, -1, 1'b0, 1'b0, 1'b0);

    // 5: lone requester keeps the grant, burst count saturates
    for (int i = 1; i <= 10; i++) begin
      step($sformatf("t5_c%0d", i), 4'b1000, 4'b1000, 4'b1000, 3, 1'b1,
           (i >= 2) ? 1'b1 : 1'b0, (i >= 2) ? 1'b1 : 1'b0);
    end
    chk("t5_sat", "cnt", 8'(dut.r_cnt), 8'd4);
    step("t5_rot", 4'b1001, 4'b1000, 4'b0001, 0,  1'b1, 1'b1, 1'b1);
    step("t5_rel", 4'b0000, 4'b1000, 4'b0000, -1, 1'b0, 1'b1, 1'b0);

    // 6: asynchronous reset mid-grant, then restart from pointer 0
    step("t6_gnt",  4'b0010, 4'b0000, 4'b0010, 1, 1'b1, 1'b1, 1'b0);
    step("t6_hold", 4'b0010, 4'b0000, 4'b0010, 1, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    push("t6_async", 4'b0000, 0, 1'b0, 1'b0, 1'b0);
    #1;
    sample();
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0010;
    push("t6_restart", 4'b0010, 1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    sample();

    chk("end", "sb_left", 8'(sb.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
